// File: rtl/tcdm_interconnect_pkg.sv
// ============================================================================
// Module : tcdm_interconnect_pkg
// Brief  : Shared types and helpers for the TCDM starvation controller.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package tcdm_interconnect_pkg;

    typedef enum logic [1:0] {
        StIdle      = 2'd0,
        StBoostBank = 2'd1,
        StBoostAll  = 2'd2,
        StCool      = 2'd3
    } starve_state_e;

    // Bits needed to hold 'value'. Never returns less than one bit.
    function automatic int unsigned sat_width(input int unsigned value);
        return (value > 1) ? $clog2(value + 1) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/tcdm_rr_pick.sv
// ============================================================================
// Module : tcdm_rr_pick
// Brief  : Finds the first set bit at or after a pointer, wrapping around.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tcdm_rr_pick #(
    parameter int unsigned NUM_IN = 16,
    parameter int unsigned IDX_W  = $clog2(NUM_IN)
) (
    input  logic [NUM_IN-1:0] i_vec,
    input  logic [IDX_W-1:0]  i_ptr,
    output logic [IDX_W-1:0]  o_idx,
    output logic              o_valid
);

    logic [IDX_W-1:0] w_cand;
    logic [IDX_W-1:0] w_idx;
    logic             w_found;

    // NUM_IN is a power of two, so the pointer sum wraps by truncation.
    always_comb begin
        w_cand  = '0;
        w_idx   = '0;
        w_found = 1'b0;
        for (int i = 0; i < NUM_IN; i++) begin
            w_cand = i_ptr + IDX_W'(i);
            if (!w_found && i_vec[w_cand]) begin
                w_found = 1'b1;
                w_idx   = w_cand;
            end
        end
    end

    assign o_idx   = w_idx;
    assign o_valid = w_found;

endmodule

`default_nettype wire

// File: rtl/tcdm_starve_ctrl.sv
// ============================================================================
// Module : tcdm_starve_ctrl
// Brief  : Tracks denied cycles per master and boosts a starving master by
//          gating same-bank competitors, then all competitors.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tcdm_starve_ctrl
    import tcdm_interconnect_pkg::*;
#(
    parameter int unsigned NUM_IN        = 16,
    parameter int unsigned NUM_OUT       = 32,
    parameter int unsigned CNT_WIDTH     = 6,
    parameter int unsigned STARVE_THRESH = 32,
    parameter int unsigned BOOST_LIMIT   = 8,
    parameter int unsigned HOLD_CYCLES   = 4,
    parameter int unsigned ADD_WIDTH     = $clog2(NUM_OUT),
    parameter int unsigned IDX_WIDTH     = $clog2(NUM_IN)
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          en_i,
    input  logic [NUM_IN-1:0]             req_i,
    input  logic [NUM_IN*ADD_WIDTH-1:0]   add_i,
    input  logic [NUM_IN-1:0]             gnt_i,
    output logic [NUM_IN-1:0]             req_o,
    output logic [NUM_IN-1:0]             gnt_o,
    output logic                          boost_o,
    output logic                          boost_all_o,
    output logic [IDX_WIDTH-1:0]          boost_idx_o,
    output logic                          starve_evt_o
);

    localparam logic [CNT_WIDTH-1:0] c_CNT_MAX   = '1;
    localparam logic [CNT_WIDTH-1:0] c_THRESH    = CNT_WIDTH'(STARVE_THRESH);
    localparam int unsigned          c_ESC_W     = sat_width(BOOST_LIMIT - 1);
    localparam logic [c_ESC_W-1:0]   c_ESC_LAST  = c_ESC_W'(BOOST_LIMIT - 1);
    localparam int unsigned          c_HOLD_VAL  = (HOLD_CYCLES > 0) ? HOLD_CYCLES - 1 : 0;
    localparam int unsigned          c_HOLD_W    = sat_width(c_HOLD_VAL);
    localparam logic [c_HOLD_W-1:0]  c_HOLD_INIT = c_HOLD_W'(c_HOLD_VAL);

    if (STARVE_THRESH > (2 ** CNT_WIDTH) - 1) begin : g_chk_thresh
        $error("STARVE_THRESH exceeds counter range");
    end
    if (BOOST_LIMIT < 1) begin : g_chk_limit
        $error("BOOST_LIMIT must be at least 1");
    end
    if ((NUM_IN < 2) || ((NUM_IN & (NUM_IN - 1)) != 0)) begin : g_chk_num_in
        $error("NUM_IN must be a power of two, at least 2");
    end
    if ((NUM_OUT < 2) || ((NUM_OUT & (NUM_OUT - 1)) != 0)) begin : g_chk_num_out
        $error("NUM_OUT must be a power of two, at least 2");
    end

    starve_state_e           r_state, w_state_nxt;
    logic [CNT_WIDTH-1:0]    r_cnt [NUM_IN];
    logic [IDX_WIDTH-1:0]    r_idx, w_idx_nxt;
    logic [IDX_WIDTH-1:0]    r_ptr, w_ptr_nxt;
    logic [c_ESC_W-1:0]      r_esc, w_esc_nxt;
    logic [c_HOLD_W-1:0]     r_hold, w_hold_nxt;
    logic                    w_evt;
    logic [NUM_IN-1:0]       w_starving;
    logic [NUM_IN-1:0]       w_req_gate;
    logic [NUM_IN-1:0]       w_idx_onehot;
    logic [ADD_WIDTH-1:0]    w_idx_add;
    logic [IDX_WIDTH-1:0]    w_pick_idx;
    logic                    w_pick_valid;

    always_comb begin
        for (int k = 0; k < NUM_IN; k++) begin
            w_starving[k] = req_i[k] && (r_cnt[k] >= c_THRESH);
        end
    end

    tcdm_rr_pick #(
        .NUM_IN (NUM_IN),
        .IDX_W  (IDX_WIDTH)
    ) u_pick (
        .i_vec   (w_starving),
        .i_ptr   (r_ptr),
        .o_idx   (w_pick_idx),
        .o_valid (w_pick_valid)
    );

    assign w_idx_onehot = NUM_IN'(1) << r_idx;
    assign w_idx_add    = add_i[r_idx*ADD_WIDTH +: ADD_WIDTH];

    // The boosted master itself is never gated, so its grant can pass at once.
    always_comb begin
        w_req_gate = req_i;
        case (r_state)
            StBoostBank: begin
                for (int k = 0; k < NUM_IN; k++) begin
                    if ((IDX_WIDTH'(k) != r_idx) &&
                        (add_i[k*ADD_WIDTH +: ADD_WIDTH] == w_idx_add)) begin
                        w_req_gate[k] = 1'b0;
                    end
                end
            end
            StBoostAll: w_req_gate = req_i & w_idx_onehot;
            default:    w_req_gate = req_i;
        endcase
    end

    assign req_o        = w_req_gate;
    assign gnt_o        = gnt_i & w_req_gate;
    assign boost_o      = (r_state == StBoostBank) || (r_state == StBoostAll);
    assign boost_all_o  = (r_state == StBoostAll);
    assign boost_idx_o  = r_idx;
    assign starve_evt_o = w_evt && !rst_i;

    // A request gated here is still a denied cycle for its master.
    always_ff @(posedge clk_i) begin
        for (int k = 0; k < NUM_IN; k++) begin
            if (rst_i || !req_i[k] || gnt_o[k]) begin
                r_cnt[k] <= '0;
            end else if (r_cnt[k] != c_CNT_MAX) begin
                r_cnt[k] <= r_cnt[k] + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_ptr_nxt   = r_ptr;
        w_esc_nxt   = r_esc;
        w_hold_nxt  = r_hold;
        w_evt       = 1'b0;
        case (r_state)
            StIdle: begin
                w_esc_nxt = '0;
                if (en_i && w_pick_valid) begin
                    w_state_nxt = StBoostBank;
                    w_idx_nxt   = w_pick_idx;
                    w_evt       = 1'b1;
                end
            end
            StBoostBank, StBoostAll: begin
                if (!en_i || !req_i[r_idx]) begin
                    w_state_nxt = StIdle;
                end else if (gnt_o[r_idx]) begin
                    w_state_nxt = (HOLD_CYCLES == 0) ? StIdle : StCool;
                    w_hold_nxt  = c_HOLD_INIT;
                    w_ptr_nxt   = r_idx + 1'b1;
                end else if (r_state == StBoostBank) begin
                    if (r_esc == c_ESC_LAST) begin
                        w_state_nxt = StBoostAll;
                    end else begin
                        w_esc_nxt = r_esc + 1'b1;
                    end
                end
            end
            StCool: begin
                if (!en_i || (r_hold == '0)) begin
                    w_state_nxt = StIdle;
                end else begin
                    w_hold_nxt = r_hold - 1'b1;
                end
            end
            default: w_state_nxt = StIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_idx  <= '0;
            r_ptr  <= '0;
            r_esc  <= '0;
            r_hold <= '0;
        end else begin
            r_idx  <= w_idx_nxt;
            r_ptr  <= w_ptr_nxt;
            r_esc  <= w_esc_nxt;
            r_hold <= w_hold_nxt;
        end
    end

    a_boost_all_onehot: assert property (@(posedge clk_i) disable iff (rst_i)
        (r_state == StBoostAll) |-> ((req_o & ~w_idx_onehot) == '0));

    a_gnt_subset: assert property (@(posedge clk_i)
        ((gnt_o & ~req_o) == '0));

endmodule

`default_nettype wire
